// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer memory arbiter.
//   FB_ADDR_W    : frame-buffer word address width
//   FB_DATA_W    : pixel/word width
//   FB_BURST_LEN : read commands issued per display grant
//   FB_STAT_W    : width of the optional statistics counters
//   fb_state_e   : arbiter state encoding
//   fb_cnt_w()   : width of the burst command/return counters
package fb_pkg;

  localparam int FB_ADDR_W    = 22;
  localparam int FB_DATA_W    = 16;
  localparam int FB_BURST_LEN = 8;
  localparam int FB_STAT_W    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    RD_WAIT = 2'd2,
    WR_CMD  = 2'd3
  } fb_state_e;

  // One extra bit so a counter can hold the value BURST_LEN itself.
  function automatic int fb_cnt_w(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/fb_mem_arbiter_sat_counter.sv
// fb_sat_counter: saturating up-counter with enable.
//   m_clock : clock
//   p_reset : synchronous active-high clear
//   en      : count this cycle
//   count   : current value, sticks at all-ones
module fb_sat_counter
  import fb_pkg::*;
#(
  parameter int W = FB_STAT_W
) (
  input  logic         m_clock,
  input  logic         p_reset,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares the frame-buffer memory command port between the
// VGA line fetcher (burst reads, always has priority) and the rasterizer
// (single-pixel writes, uses remaining slots).
//
// Ports:
//   m_clock, p_reset              clock, synchronous active-high reset
//   disp_req/addr/ack             display burst request handshake
//   disp_rdata/rvalid/done        returned burst data and end-of-burst pulse
//   rast_req/addr/wdata/ack       rasterizer pixel write handshake
//   mem_cmd_*, mem_wdata          command port toward the SDRAM controller
//   mem_rdata/rvalid              in-order read returns from the controller
//   busy                          arbiter not idle
//   stat_rast_stall, stat_bursts  statistics, built only with FB_ARB_STATS_EN
//
// Build option: define FB_ARB_STATS_EN to build the saturating statistics
// counters; otherwise both stat outputs are tied to zero.
//
// state   | meaning
// IDLE    | no grant; samples requests, display first
// RD_CMD  | issuing BURST_LEN read commands from base, collecting returns
// RD_WAIT | all reads issued, waiting for the remaining returns
// WR_CMD  | presenting one pixel write until memory accepts it
module fb_mem_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W,
  parameter int BURST_LEN = FB_BURST_LEN
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  output logic              disp_done,
  input  logic              rast_req,
  input  logic [ADDR_W-1:0] rast_addr,
  input  logic [DATA_W-1:0] rast_wdata,
  output logic              rast_ack,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic [15:0]       stat_rast_stall,
  output logic [15:0]       stat_bursts
);

  localparam int               CNT_W = fb_cnt_w(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(BURST_LEN);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic              rd_phase;
  logic              ret_fire;

  assign rd_phase = (state_q == RD_CMD) || (state_q == RD_WAIT);
  // Returns outside a read burst are dropped; see the assertion below.
  assign ret_fire = rd_phase && mem_rvalid && !p_reset;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    cmd_cnt_d     = cmd_cnt_q;
    ret_cnt_d     = ret_cnt_q;
    disp_ack      = 1'b0;
    rast_ack      = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_we    = 1'b0;
    mem_cmd_addr  = '0;
    mem_wdata     = '0;

    if (ret_fire) ret_cnt_d = ret_cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (disp_req) begin
          disp_ack  = 1'b1;
          base_d    = disp_addr;
          cmd_cnt_d = '0;
          ret_cnt_d = '0;
          state_d   = RD_CMD;
        end else if (rast_req) begin
          waddr_d = rast_addr;
          wdata_d = rast_wdata;
          state_d = WR_CMD;
        end
      end
      RD_CMD: begin
        mem_cmd_valid = 1'b1;
        // Burst addresses wrap at the top of memory.
        mem_cmd_addr  = base_q + ADDR_W'(cmd_cnt_q);
        if (mem_cmd_ready) begin
          cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
          if (cmd_cnt_q == LAST) state_d = (ret_cnt_d == FULL) ? IDLE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (ret_fire && (ret_cnt_q == LAST)) state_d = IDLE;
      end
      WR_CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_we    = 1'b1;
        mem_cmd_addr  = waddr_q;
        mem_wdata     = wdata_q;
        if (mem_cmd_ready) begin
          rast_ack = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A reset cycle issues no handshakes and no commands.
    if (p_reset) begin
      disp_ack      = 1'b0;
      rast_ack      = 1'b0;
      mem_cmd_valid = 1'b0;
      mem_cmd_we    = 1'b0;
    end
  end

  assign disp_rvalid = ret_fire;
  assign disp_rdata  = ret_fire ? mem_rdata : '0;
  assign disp_done   = ret_fire && (ret_cnt_q == LAST);
  assign busy        = (state_q != IDLE);

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      cmd_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      cmd_cnt_q <= cmd_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  // Read data may only arrive while a burst is outstanding.
  a_rvalid_in_burst : assert property (@(posedge m_clock) disable iff (p_reset)
    mem_rvalid |-> rd_phase);

`ifdef FB_ARB_STATS_EN
  fb_sat_counter #(.W(16)) u_stat_stall (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .en      (rast_req && !rast_ack),
    .count   (stat_rast_stall)
  );

  fb_sat_counter #(.W(16)) u_stat_bursts (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .en      (disp_done),
    .count   (stat_bursts)
  );
`else
  assign stat_rast_stall = '0;
  assign stat_bursts     = '0;
`endif

endmodule
